// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory (DEPTH x 32-bit, word
// indexed, combinational read, write on posedge clk) between the CPU
// load/store port (A) and a loader/debug port (B).
//
// Each access runs IDLE -> ACCESS -> RESP. The winning request is latched
// at the grant edge, drives exactly one memory cycle in ACCESS, and is
// acknowledged in RESP with a one-cycle ack (plus err when out of range).
// In RESP a pending request from the other port is granted directly, so
// alternating ports take one access per two cycles.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin on ties in IDLE
//                   undefined -> fixed priority, port A wins ties
module dmem_arbiter #(
  parameter int unsigned DEPTH = 100
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,

  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Owner of the latched request: 0 = port A, 1 = port B.
  logic        owner_q;
  logic        lat_we_q;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;

  logic        grant;
  logic        grant_b;
  logic        tie_pick_b;
  logic        in_range;

  // Full 32-bit unsigned compare; no truncation of the address.
  assign in_range = (lat_addr_q < DEPTH);

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: 1 when port B was granted last. Resets to
  // "last served B" so port A wins the first tie.
  logic last_b_q;

  // Tie winner is the port not served most recently.
  always_comb begin
    tie_pick_b = ~last_b_q;
  end

  // Pointer follows every grant, including RESP hand-overs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_b_q <= 1'b1;
    end else if (grant) begin
      last_b_q <= grant_b;
    end
  end
`else
  // Fixed priority: port A always wins a tie.
  always_comb begin
    tie_pick_b = 1'b0;
  end
`endif

  // Next-state and grant selection.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          grant   = 1'b1;
          grant_b = (a_req && b_req) ? tie_pick_b : b_req;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        // Owner's req is still high from the handshake and is ignored;
        // only the other port can be handed the memory here.
        if (owner_q ? a_req : b_req) begin
          grant   = 1'b1;
          grant_b = ~owner_q;
          state_d = S_ACCESS;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the granted port's command and remember the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else if (grant) begin
      owner_q     <= grant_b;
      lat_we_q    <= grant_b ? b_we    : a_we;
      lat_addr_q  <= grant_b ? b_addr  : a_addr;
      lat_wdata_q <= grant_b ? b_wdata : a_wdata;
    end
  end

  // Capture read data for the owner at the end of ACCESS; out-of-range
  // reads return zero and writes leave both rdata registers untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state_q == S_ACCESS && !lat_we_q) begin
      if (owner_q) begin
        b_rdata <= in_range ? mem_rdata : '0;
      end else begin
        a_rdata <= in_range ? mem_rdata : '0;
      end
    end
  end

  // Memory drive: only during ACCESS, zero otherwise. Decoded from the
  // state register so an asynchronous reset drops mem_we at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_ACCESS) begin
      mem_we    = lat_we_q && in_range;
      mem_addr  = lat_addr_q;
      mem_wdata = lat_wdata_q;
    end
  end

  // Response pulses and busy flag.
  always_comb begin
    a_ack = 1'b0;
    a_err = 1'b0;
    b_ack = 1'b0;
    b_err = 1'b0;
    busy  = (state_q != S_IDLE);
    if (state_q == S_RESP) begin
      if (owner_q) begin
        b_ack = 1'b1;
        b_err = ~in_range;
      end else begin
        a_ack = 1'b1;
        a_err = ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a simple
// 100-word memory attached to the mem_* port. Inputs change and outputs
// are sampled on the falling edge of clk.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;

  logic [31:0] mem [0:99];

  int unsigned nvec;
  int unsigned nerr;

  dmem_arbiter #(.DEPTH(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .a_err     (a_err),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .b_err     (b_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, out-of-range reads return a marker
  // value so a missing zero-fill in the arbiter shows up.
  assign mem_rdata = (mem_addr < 32'd100) ? mem[mem_addr[6:0]] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'd100) mem[mem_addr[6:0]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pb, input bit req, input bit we,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (pb) begin
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
    end
  endtask

  // One access on one port; req is held through RESP and the following
  // IDLE cycle, then dropped, so a regrant in RESP would be visible.
  task automatic single(input string tag, input bit pb, input bit we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input bit exp_we);
    @(negedge clk);
    drive(pb, 1'b1, we, addr, wd);
    @(negedge clk);
    chk({tag, "/acc_busy"},  32'(busy), 32'd1);
    chk({tag, "/acc_addr"},  mem_addr, addr);
    chk({tag, "/acc_we"},    32'(mem_we), 32'(exp_we));
    chk({tag, "/acc_wdata"}, mem_wdata, wd);
    chk({tag, "/acc_noack"}, 32'({a_ack, b_ack}), 32'd0);
    @(negedge clk);
    chk({tag, "/rsp_ack"},   32'({a_ack, b_ack}), pb ? 32'd1 : 32'd2);
    chk({tag, "/rsp_err"},   32'(pb ? b_err : a_err), 32'(exp_err));
    chk({tag, "/rsp_rdata"}, pb ? b_rdata : a_rdata, exp_rd);
    chk({tag, "/rsp_memwe"}, 32'(mem_we), 32'd0);
    @(negedge clk);
    chk({tag, "/idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "/idle_ack"},  32'({a_ack, b_ack}), 32'd0);
    drive(pb, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk({tag, "/no_extra"},  32'(busy), 32'd0);
  endtask

  // Simultaneous requests: A reads 5, B reads 7; the winner is served
  // first and the other port is handed the memory directly from RESP.
  task automatic tie(input string tag, input bit first_b,
                     input logic [31:0] a_exp, input logic [31:0] b_exp);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd5, '0);
    drive(1'b1, 1'b1, 1'b0, 32'd7, '0);
    @(negedge clk);
    chk({tag, "/first_addr"}, mem_addr, first_b ? 32'd7 : 32'd5);
    @(negedge clk);
    chk({tag, "/first_ack"},  32'({a_ack, b_ack}), first_b ? 32'd1 : 32'd2);
    drive(first_b, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk({tag, "/hand_busy"},  32'(busy), 32'd1);
    chk({tag, "/hand_addr"},  mem_addr, first_b ? 32'd5 : 32'd7);
    chk({tag, "/hand_noack"}, 32'({a_ack, b_ack}), 32'd0);
    @(negedge clk);
    chk({tag, "/second_ack"}, 32'({a_ack, b_ack}), first_b ? 32'd2 : 32'd1);
    chk({tag, "/a_rdata"},    a_rdata, a_exp);
    chk({tag, "/b_rdata"},    b_rdata, b_exp);
    drive(~first_b, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk({tag, "/idle"},       32'(busy), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "/busy"},    32'(busy), 32'd0);
    chk({tag, "/acks"},    32'({a_ack, b_ack, a_err, b_err}), 32'd0);
    chk({tag, "/mem_we"},  32'(mem_we), 32'd0);
    chk({tag, "/mem_adr"}, mem_addr, 32'd0);
    chk({tag, "/mem_wd"},  mem_wdata, 32'd0);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    reset = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 100; i++) mem[i] = 32'h1000 + 32'(i);
    mem[5] = 32'h0000_1234;
    mem[3] = 32'h0000_0033;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    chk("reset/a_rdata", a_rdata, 32'd0);
    chk("reset/b_rdata", b_rdata, 32'd0);
    reset = 1'b1;

    // Basic A read, B write, A read-back, out-of-range write and read
    single("a_rd5",   1'b0, 1'b0, 32'd5,          '0,            32'h0000_1234, 1'b0, 1'b0);
    single("b_wr7",   1'b1, 1'b1, 32'd7,          32'hDEADBEEF,  32'd0,         1'b0, 1'b1);
    chk("b_wr7/mem7", mem[7], 32'hDEADBEEF);
    single("a_rd7",   1'b0, 1'b0, 32'd7,          '0,            32'hDEADBEEF,  1'b0, 1'b0);
    single("a_wr100", 1'b0, 1'b1, 32'd100,        32'h0000_CAFE, 32'hDEADBEEF,  1'b1, 1'b0);
    single("a_rdmax", 1'b0, 1'b0, 32'hFFFF_FFFF,  '0,            32'd0,         1'b1, 1'b0);
    single("b_rd99",  1'b1, 1'b0, 32'd99,         '0,            32'h0000_1063, 1'b0, 1'b0);

    // Tie straight after reset: A wins in both arbitration modes
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tie("tie0", 1'b0, 32'h0000_1234, 32'hDEADBEEF);

    // Reset while a write to addr 3 is in ACCESS
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'd3, 32'h0000_0055);
    @(negedge clk);
    chk("rst_acc/mem_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_quiet("rst_acc/async");
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("rst_acc/mem3", mem[3], 32'h0000_0033);
    chk("rst_acc/a_rdata", a_rdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check_quiet("rst_acc/after");
    single("a_rd3", 1'b0, 1'b0, 32'd3, '0, 32'h0000_0033, 1'b0, 1'b0);

    // Tie after A was served last: round-robin favours B, fixed favours A
    single("a_rd5b", 1'b0, 1'b0, 32'd5, '0, 32'h0000_1234, 1'b0, 1'b0);
`ifdef DMEM_ARB_RR_EN
    tie("tie1", 1'b1, 32'h0000_1234, 32'hDEADBEEF);
`else
    tie("tie1", 1'b0, 32'h0000_1234, 32'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
